// File: rtl/mmio_timer_resp_if.sv
// Data-memory port bundle between the CPU MEM stage (master) and a memory-mapped responder (slave).
interface mmio_timer_resp_if;
    logic        ce;
    logic        we;
    logic        memRr;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [3:0]  w_mask;
    logic [3:0]  r_mask;
    logic [31:0] rdData;
    logic        hit;

    modport master (output ce, we, memRr, addr, wtData, w_mask, r_mask, input rdData, hit);
    modport slave  (input ce, we, memRr, addr, wtData, w_mask, r_mask, output rdData, hit);
endinterface

// File: rtl/mmio_timer_resp.sv
// Memory-mapped prescaled timer with compare/match interrupt on the data-memory port.
// Optional input-capture unit enabled by defining TIMER_CAPTURE_EN.
module mmio_timer_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mmio_timer_resp_if.slave bus,
`ifdef TIMER_CAPTURE_EN
    input  logic             cap_in,
`endif
    output logic             irq
);
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_CAPTURE  = 3'd5;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                               input logic [3:0] mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] keepLanes(input logic [31:0] val, input logic [3:0] mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? val[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    logic [2:0]            ctrl_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] pcnt_r;
    logic [31:0]           count_r;
    logic [31:0]           compare_r;
    logic                  match_r;
    logic                  irq_r;
    logic                  capFlag_s;
    logic [31:0]           capture_s;

    logic                  hit_s;
    logic [2:0]            offset_s;
    logic                  wrAny_s;
    logic                  tick_s;
    logic                  matchSet_s;
    logic [2:0]            ctrlNext_s;
    logic [PRESCALE_W-1:0] prescaleNext_s;
    logic [PRESCALE_W-1:0] pcntNext_s;
    logic [31:0]           countNext_s;
    logic [31:0]           compareNext_s;
    logic                  matchNext_s;
    logic [31:0]           regVal_s;

    assign hit_s    = bus.ce && (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign offset_s = bus.addr[4:2];
    assign wrAny_s  = hit_s && bus.we && (bus.w_mask != 4'b0000);
    assign tick_s   = ctrl_r[0] && (pcnt_r == prescale_r);
    assign bus.hit  = hit_s;
    assign irq      = irq_r;

    // Next-state for control, prescaler, counter, compare and match flag.
    always_comb begin
        ctrlNext_s     = ctrl_r;
        prescaleNext_s = prescale_r;
        pcntNext_s     = pcnt_r;
        countNext_s    = count_r;
        compareNext_s  = compare_r;
        matchSet_s     = tick_s && (count_r == compare_r);

        if (wrAny_s && (offset_s == OFF_CTRL) && bus.w_mask[0]) begin
            ctrlNext_s = bus.wtData[2:0];
        end else begin
            ctrlNext_s = ctrl_r;
        end

        if (wrAny_s && (offset_s == OFF_PRESCALE)) begin
            for (int b = 0; b < PRESCALE_W; b++) begin
                prescaleNext_s[b] = bus.w_mask[b/8] ? bus.wtData[b] : prescale_r[b];
            end
        end else begin
            prescaleNext_s = prescale_r;
        end

        // A prescale rewrite or EN dropping restarts the divider phase.
        if (!ctrl_r[0] || !ctrlNext_s[0] || (wrAny_s && (offset_s == OFF_PRESCALE))) begin
            pcntNext_s = {PRESCALE_W{1'b0}};
        end else if (tick_s) begin
            pcntNext_s = {PRESCALE_W{1'b0}};
        end else begin
            pcntNext_s = pcnt_r + PRESCALE_W'(1);
        end

        if (wrAny_s && (offset_s == OFF_COUNT)) begin
            countNext_s = mergeBytes(count_r, bus.wtData, bus.w_mask);
        end else if (matchSet_s) begin
            countNext_s = ctrl_r[1] ? 32'h0000_0000 : count_r;
        end else if (tick_s) begin
            countNext_s = count_r + 32'd1;
        end else begin
            countNext_s = count_r;
        end

        if (wrAny_s && (offset_s == OFF_COMPARE)) begin
            compareNext_s = mergeBytes(compare_r, bus.wtData, bus.w_mask);
        end else begin
            compareNext_s = compare_r;
        end

        matchNext_s = matchSet_s ||
                      (match_r && !(wrAny_s && (offset_s == OFF_STATUS) && bus.w_mask[0] && bus.wtData[0]));
    end

    // Register-file read mux with per-lane masking; reads have no side effects.
    always_comb begin
        regVal_s = 32'h0000_0000;
        case (offset_s)
            OFF_CTRL:     regVal_s = {29'h0, ctrl_r};
            OFF_PRESCALE: regVal_s = 32'(prescale_r);
            OFF_COUNT:    regVal_s = count_r;
            OFF_COMPARE:  regVal_s = compare_r;
            OFF_STATUS:   regVal_s = {30'h0, capFlag_s, match_r};
            OFF_CAPTURE:  regVal_s = capture_s;
            default:      regVal_s = 32'h0000_0000;
        endcase
        if (hit_s && bus.memRr) begin
            bus.rdData = keepLanes(regVal_s, bus.r_mask);
        end else begin
            bus.rdData = 32'h0000_0000;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r     <= 3'b000;
            prescale_r <= {PRESCALE_W{1'b0}};
            pcnt_r     <= {PRESCALE_W{1'b0}};
            count_r    <= 32'h0000_0000;
            compare_r  <= 32'hFFFF_FFFF;
            match_r    <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            ctrl_r     <= ctrlNext_s;
            prescale_r <= prescaleNext_s;
            pcnt_r     <= pcntNext_s;
            count_r    <= countNext_s;
            compare_r  <= compareNext_s;
            match_r    <= matchNext_s;
            irq_r      <= match_r && ctrl_r[2];
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic        capSync1_r;
    logic        capSync2_r;
    logic        capPrev_r;
    logic        capFlag_r;
    logic [31:0] capture_r;
    logic        capEdge_s;

    assign capEdge_s = capSync2_r && !capPrev_r;
    assign capFlag_s = capFlag_r;
    assign capture_s = capture_r;

    // Synchronise cap_in, detect its rising edge and snapshot the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            capSync1_r <= 1'b0;
            capSync2_r <= 1'b0;
            capPrev_r  <= 1'b0;
            capFlag_r  <= 1'b0;
            capture_r  <= 32'h0000_0000;
        end else begin
            capSync1_r <= cap_in;
            capSync2_r <= capSync1_r;
            capPrev_r  <= capSync2_r;
            capFlag_r  <= capEdge_s ||
                          (capFlag_r && !(wrAny_s && (offset_s == OFF_STATUS) && bus.w_mask[0] && bus.wtData[1]));
            capture_r  <= capEdge_s ? count_r : capture_r;
        end
    end
`else
    assign capFlag_s = 1'b0;
    assign capture_s = 32'h0000_0000;
`endif
endmodule

// File: tb/tb_mmio_timer_resp.sv
// Scoreboard bench for mmio_timer_resp: directed scenarios plus random bus traffic vs an arithmetic model.
module tb_mmio_timer_resp;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
    } rdExp_t;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    logic capIn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rdExp_t rdQ[$];
    logic   irqQ[$];

    always #5 clk = ~clk;

    mmio_timer_resp_if bus ();

    mmio_timer_resp #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
`ifdef TIMER_CAPTURE_EN
        .cap_in (capIn),
`endif
        .irq    (irq)
    );

    // Reference model state: plain architectural values.
    logic [2:0]  mCtrl;
    int unsigned mPre;
    longint      mEnCycles;   // enabled cycles since the divider last restarted
    logic [31:0] mCount;
    logic [31:0] mCompare;
    logic        mMatch;
    logic        mIrq;
    logic        mCap;
    logic [31:0] mCapture;
    logic [2:0]  mCapHist;    // cap_in as seen 1,2,3 edges ago

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] off, input logic [3:0] rm);
        logic [31:0] v;
        logic [31:0] r;
        case (off)
            3'd0:    v = {29'h0, mCtrl};
            3'd1:    v = mPre;
            3'd2:    v = mCount;
            3'd3:    v = mCompare;
`ifdef TIMER_CAPTURE_EN
            3'd4:    v = {30'h0, mCap, mMatch};
            3'd5:    v = mCapture;
`else
            3'd4:    v = {31'h0, mMatch};
`endif
            default: v = 32'h0;
        endcase
        for (int i = 0; i < 4; i++) r[8*i +: 8] = rm[i] ? v[8*i +: 8] : 8'h00;
        return r;
    endfunction

    task automatic modelReset();
        mCtrl = 3'b000; mPre = 0; mEnCycles = 0; mCount = 32'h0; mCompare = 32'hFFFF_FFFF;
        mMatch = 1'b0; mIrq = 1'b0; mCap = 1'b0; mCapture = 32'h0; mCapHist = 3'b000;
    endtask

    task automatic modelEdge(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] wm);
        logic        wr;
        logic [2:0]  off;
        logic        tick;
        logic        hitCmp;
        logic [2:0]  nCtrl;
        logic [31:0] preWide;
        logic        capRise;
        wr      = c && (a[31:5] == BASE[31:5]) && w && (wm != 4'h0);
        off     = a[4:2];
        tick    = mCtrl[0] && ((mEnCycles % (longint'(mPre) + 1)) == longint'(mPre));
        hitCmp  = tick && (mCount == mCompare);
        capRise = mCapHist[1] && !mCapHist[2];
        nCtrl   = (wr && off == 3'd0 && wm[0]) ? d[2:0] : mCtrl;
        mIrq    = mMatch && mCtrl[2];
        if (wr && off == 3'd4 && wm[0] && d[1]) mCap = 1'b0;
        if (capRise) begin mCap = 1'b1; mCapture = mCount; end
        mCapHist = {mCapHist[1:0], capIn};
        if (wr && off == 3'd4 && wm[0] && d[0]) mMatch = 1'b0;
        if (hitCmp) mMatch = 1'b1;
        if (wr && off == 3'd2) mCount = merge(mCount, d, wm);
        else if (hitCmp) mCount = mCtrl[1] ? 32'h0 : mCount;
        else if (tick) mCount = mCount + 32'd1;
        if (wr && off == 3'd3) mCompare = merge(mCompare, d, wm);
        if (!mCtrl[0] || !nCtrl[0] || (wr && off == 3'd1)) mEnCycles = 0;
        else mEnCycles = mEnCycles + 1;
        if (wr && off == 3'd1) begin
            preWide = merge(mPre, d, wm);
            mPre = {16'h0, preWide[15:0]};
        end
        mCtrl = nCtrl;
    endtask

    task automatic access(input logic c, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] wm, input logic [3:0] rm);
        rdExp_t e;
        bus.ce = c; bus.we = w; bus.memRr = r; bus.addr = a;
        bus.wtData = d; bus.w_mask = wm; bus.r_mask = rm;
        irqQ.push_back(mIrq);
        if (r) begin
            e.hit  = c && (a[31:5] == BASE[31:5]);
            e.data = e.hit ? modelRead(a[4:2], rm) : 32'h0;
            rdQ.push_back(e);
        end
        modelEdge(c, w, a, d, wm);
        @(posedge clk);
        #1;
    endtask

    task automatic wrReg(input int off, input logic [31:0] d, input logic [3:0] wm);
        access(1'b1, 1'b1, 1'b0, BASE + 32'(off * 4), d, wm, 4'h0);
    endtask

    task automatic rdReg(input int off, input logic [3:0] rm);
        access(1'b1, 1'b0, 1'b1, BASE + 32'(off * 4), 32'h0, 4'h0, rm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    // Monitor: compares irq every cycle and rdData/hit whenever a read is presented.
    always @(negedge clk) begin
        logic   eIrq;
        rdExp_t e;
        if (irqQ.size() > 0) begin
            eIrq = irqQ.pop_front();
            total++;
            if (irq !== eIrq) begin
                bad++;
                $display("FAIL irq at %0t: got %b want %b", $time, irq, eIrq);
            end
        end
        if (bus.memRr === 1'b1) begin
            total++;
            if (rdQ.size() == 0) begin
                bad++;
                $display("FAIL rdq_underflow at %0t: got read with no expectation", $time);
            end else begin
                e = rdQ.pop_front();
                if (bus.rdData !== e.data || bus.hit !== e.hit) begin
                    bad++;
                    $display("FAIL rdData/hit at %0t addr=%h: got %h/%b want %h/%b",
                             $time, bus.addr, bus.rdData, bus.hit, e.data, e.hit);
                end
            end
        end
    end

    initial begin
        int kind;
        int off;
        logic [31:0] d;
        rst = 1'b1;
        bus.ce = 1'b0; bus.we = 1'b0; bus.memRr = 1'b0; bus.addr = 32'h0;
        bus.wtData = 32'h0; bus.w_mask = 4'h0; bus.r_mask = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        // Reset values of every offset.
        for (int o = 0; o < 8; o++) rdReg(o, 4'hF);

        // Auto-reload match cadence and interrupt, then W1C.
        wrReg(1, 32'd3, 4'hF);
        wrReg(3, 32'd5, 4'hF);
        wrReg(0, 32'h7, 4'hF);
        for (int i = 0; i < 30; i++) rdReg(4, 4'hF);
        wrReg(4, 32'h1, 4'hF);
        rdReg(4, 4'hF);
        idle(2);
        wrReg(0, 32'h0, 4'hF);

        // Byte-masked write and masked reads.
        wrReg(2, 32'h0, 4'hF);
        wrReg(2, 32'hAABB_CCDD, 4'b0101);
        rdReg(2, 4'hF);
        rdReg(2, 4'b0010);
        rdReg(2, 4'b0100);

        // Non-reload park at COMPARE, W1C racing a re-match; read+write same cycle.
        wrReg(2, 32'h0, 4'hF);
        wrReg(3, 32'd2, 4'hF);
        wrReg(1, 32'd0, 4'hF);
        wrReg(0, 32'h1, 4'hF);
        for (int i = 0; i < 5; i++) rdReg(2, 4'hF);
        wrReg(4, 32'h1, 4'hF);
        rdReg(4, 4'hF);
        access(1'b1, 1'b1, 1'b1, BASE + 32'h8, 32'h0000_0010, 4'hF, 4'hF);
        rdReg(2, 4'hF);

        // Out-of-window and ce=0 accesses; COUNT write racing a tick.
        wrReg(0, 32'h0, 4'hF);
        wrReg(3, 32'hFFFF_FFFF, 4'hF);
        access(1'b1, 1'b1, 1'b1, BASE + 32'h28, 32'h1234_5678, 4'hF, 4'hF);
        access(1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'h1234_5678, 4'hF, 4'hF);
        rdReg(2, 4'hF);
        wrReg(0, 32'h1, 4'hF);
        idle(3);
        wrReg(2, 32'd100, 4'hF);
        rdReg(2, 4'hF);
        rdReg(2, 4'hF);

`ifdef TIMER_CAPTURE_EN
        // Capture of a running counter through the synchronizer.
        wrReg(0, 32'h0, 4'hF);
        wrReg(1, 32'd1000, 4'hF);
        wrReg(2, 32'd7, 4'hF);
        wrReg(0, 32'h1, 4'hF);
        capIn = 1'b1;
        idle(1);
        capIn = 1'b0;
        for (int i = 0; i < 4; i++) rdReg(5, 4'hF);
        rdReg(4, 4'hF);
        wrReg(4, 32'h2, 4'hF);
        rdReg(4, 4'hF);
`endif

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            off  = $urandom_range(0, 7);
            case (off)
                1:       d = $urandom_range(0, 3);
                2, 3:    d = $urandom_range(0, 12);
                default: d = $urandom;
            endcase
`ifdef TIMER_CAPTURE_EN
            if ($urandom_range(0, 7) == 0) capIn = ~capIn;
`endif
            if (kind <= 3) rdReg(off, 4'($urandom));
            else if (kind <= 6) wrReg(off, d, 4'($urandom));
            else if (kind == 7) idle(1);
            else if (kind == 8) access($urandom_range(0, 1) == 1, 1'b1, 1'b1,
                                       BASE + 32'h20 + 32'(off * 4), d, 4'hF, 4'hF);
            else access(1'b1, 1'b1, 1'b1, BASE + 32'(off * 4), d, 4'($urandom), 4'($urandom));
        end
        idle(2);

        total++;
        if (rdQ.size() != 0 || irqQ.size() != 0) begin
            bad++;
            $display("FAIL queues_drained: got rd=%0d irq=%0d pending want 0", rdQ.size(), irqQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
